// File: rtl/diferencial_pkg.sv
// Shared definitions for the differential receiver controller.
// State encoding and default timing parameters.
// Imported by the controller top and its counter sub-module.
package diferencial_pkg;

  typedef enum logic [1:0] {
    ST_OFF    = 2'd0,
    ST_IDLE   = 2'd1,
    ST_WAKE   = 2'd2,
    ST_ACTIVE = 2'd3
  } state_t;

  localparam int DEF_IDLE_TIMEOUT = 16;
  localparam int DEF_WAKE_TRANS   = 4;
  localparam int DEF_CNT_W        = 5;

endpackage

// File: rtl/diferencial_edge_cnt.sv
// Saturating event counter with synchronous clear and a limit flag.
// at_lim is combinational: high when one more increment would reach LIMIT.
// Clear has priority over increment; the count holds at all-ones.
module diferencial_edge_cnt
  import diferencial_pkg::*;
#(
  parameter int LIMIT = DEF_WAKE_TRANS,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic at_lim
);

  localparam logic [CNT_W-1:0] LIM_M1 = CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] cnt;

  // Flag the cycle whose increment lands exactly on LIMIT.
  assign at_lim = (cnt == LIM_M1);

  // Count events, clearing on request and saturating instead of wrapping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/diferencial_rx_ctrl.sv
// Differential receiver sequencer: enable gating, wake qualification, idle tracking.
// Registered outputs; rx_data/rx_valid lag dp/dn by one cycle while ACTIVE.
// No backpressure: enb_req low forces OFF on the next edge from any state.
module diferencial_rx_ctrl
  import diferencial_pkg::*;
#(
  parameter int IDLE_TIMEOUT = DEF_IDLE_TIMEOUT,
  parameter int WAKE_TRANS   = DEF_WAKE_TRANS,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enb_req,
  input  logic       dp,
  input  logic       dn,
  output logic       rx_enb,
  output logic       rx_data,
  output logic       rx_valid,
  output logic       elec_idle,
  output logic [1:0] state_o
);

  state_t state, state_nxt;
  logic   last_dp;
  logic   diff, trans;
  logic   t_inc, t_clr, t_lim;
  logic   q_inc, q_clr, q_lim;
  logic   act_hold;

  assign diff     = dp ^ dn;
  assign trans    = diff & (dp ^ last_dp);
  assign state_o  = state;
  // Serial data is only forwarded while the link stays ACTIVE across the edge.
  assign act_hold = (state == ST_ACTIVE) && (state_nxt == ST_ACTIVE);

  diferencial_edge_cnt #(.LIMIT(WAKE_TRANS), .CNT_W(CNT_W)) u_trans_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr    (t_clr),
    .inc    (t_inc),
    .at_lim (t_lim)
  );

  diferencial_edge_cnt #(.LIMIT(IDLE_TIMEOUT), .CNT_W(CNT_W)) u_quiet_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr    (q_clr),
    .inc    (q_inc),
    .at_lim (q_lim)
  );

  // Next-state and counter control; enb_req low overrides everything.
  always_comb begin
    state_nxt = state;
    t_inc     = 1'b0;
    t_clr     = 1'b0;
    q_inc     = 1'b0;
    q_clr     = 1'b0;
    if (!enb_req) begin
      state_nxt = ST_OFF;
      t_clr     = 1'b1;
      q_clr     = 1'b1;
    end else begin
      case (state)
        ST_OFF: begin
          state_nxt = ST_IDLE;
          t_clr     = 1'b1;
          q_clr     = 1'b1;
        end
        ST_IDLE: begin
          t_clr = 1'b1;
          q_clr = 1'b1;
          if (diff) state_nxt = ST_WAKE;
        end
        ST_WAKE: begin
          q_clr = 1'b1;
          if (!diff) begin
            state_nxt = ST_IDLE;
            t_clr     = 1'b1;
          end else if (trans) begin
            t_inc = 1'b1;
            if (t_lim) begin
              state_nxt = ST_ACTIVE;
              t_clr     = 1'b1;
            end
          end
        end
        ST_ACTIVE: begin
          t_clr = 1'b1;
          if (trans) begin
            // A transition always restarts the quiet window, even on the timeout cycle.
            q_clr = 1'b1;
          end else begin
            q_inc = 1'b1;
            if (q_lim) begin
              state_nxt = ST_IDLE;
              q_clr     = 1'b1;
            end
          end
        end
        default: begin
          state_nxt = ST_OFF;
          t_clr     = 1'b1;
          q_clr     = 1'b1;
        end
      endcase
    end
  end

  // State, last differential level and registered outputs derived from the next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_OFF;
      last_dp   <= 1'b0;
      rx_enb    <= 1'b0;
      rx_data   <= 1'b0;
      rx_valid  <= 1'b0;
      elec_idle <= 1'b1;
    end else begin
      state     <= state_nxt;
      if (diff) last_dp <= dp;
      rx_enb    <= (state_nxt != ST_OFF);
      elec_idle <= (state_nxt != ST_ACTIVE);
      rx_valid  <= act_hold & diff;
      rx_data   <= act_hold & dp;
    end
  end

endmodule

// File: tb/tb_diferencial_rx_ctrl.sv
// Bench for the differential receiver controller.
// A behavioural model follows the state rules with integer counters.
// Directed scenarios first, then randomized traffic with async resets.
module tb_diferencial_rx_ctrl;

  localparam int IDLE_TO = 16;
  localparam int WAKE_N  = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enb_req = 1'b0;
  logic       dp = 1'b0;
  logic       dn = 1'b0;
  logic       rx_enb, rx_data, rx_valid, elec_idle;
  logic [1:0] state_o;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // Model state: state number 0..3, counters, last differential dp, expected outputs.
  int m_st = 0;
  int m_tc = 0;
  int m_qc = 0;
  bit m_last = 1'b0;
  bit m_enb = 1'b0, m_data = 1'b0, m_valid = 1'b0, m_idle = 1'b1;

  diferencial_rx_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .enb_req   (enb_req),
    .dp        (dp),
    .dn        (dn),
    .rx_enb    (rx_enb),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .elec_idle (elec_idle),
    .state_o   (state_o)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  // Reference behaviour evaluated at each rising edge.
  always @(posedge clk or negedge rst) begin
    bit d, t, act;
    int ns;
    if (!rst) begin
      m_st = 0; m_tc = 0; m_qc = 0; m_last = 1'b0;
      m_enb = 1'b0; m_data = 1'b0; m_valid = 1'b0; m_idle = 1'b1;
    end else begin
      d  = (dp != dn);
      t  = d && (dp != m_last);
      ns = m_st;
      if (!enb_req) begin
        ns = 0; m_tc = 0; m_qc = 0;
      end else if (m_st == 0) begin
        ns = 1;
      end else if (m_st == 1) begin
        if (d) begin ns = 2; m_tc = 0; end
      end else if (m_st == 2) begin
        if (!d) begin
          ns = 1; m_tc = 0;
        end else if (t) begin
          m_tc = m_tc + 1;
          if (m_tc == WAKE_N) begin ns = 3; m_tc = 0; m_qc = 0; end
        end
      end else begin
        if (t) m_qc = 0;
        else begin
          m_qc = m_qc + 1;
          if (m_qc == IDLE_TO) begin ns = 1; m_qc = 0; end
        end
      end
      act     = (m_st == 3) && (ns == 3);
      m_enb   = (ns != 0);
      m_idle  = (ns != 3);
      m_valid = act && d;
      m_data  = act && dp;
      if (d) m_last = dp;
      m_st = ns;
    end
  end

  // Every-cycle comparison against the model, away from the rising edge.
  always @(negedge clk) begin
    if (chk_en) begin
      cmp("state_o", int'(state_o), m_st);
      cmp("rx_enb", int'(rx_enb), int'(m_enb));
      cmp("elec_idle", int'(elec_idle), int'(m_idle));
      cmp("rx_valid", int'(rx_valid), int'(m_valid));
      cmp("rx_data", int'(rx_data), int'(m_data));
    end
  end

  // Apply one cycle of inputs; returns 1 time unit after the rising edge.
  task automatic cyc(input logic e, input logic p, input logic n);
    enb_req = e; dp = p; dn = n;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    int mode;
    bit cur;

    // Reset held with enb_req high and the pair toggling.
    rst = 1'b0;
    @(posedge clk); #1;
    chk_en = 1'b1;
    for (int i = 0; i < 4; i++) cyc(1'b1, i[0], ~i[0]);
    cmp("rst_state", int'(state_o), 0);
    cmp("rst_rx_enb", int'(rx_enb), 0);
    cmp("rst_elec_idle", int'(elec_idle), 1);

    // Release: first edge applies the OFF rules.
    rst = 1'b1;
    cyc(1'b1, 1'b0, 1'b0);
    cmp("rel_state", int'(state_o), 1);
    cmp("rel_rx_enb", int'(rx_enb), 1);

    // Wake-up sequence.
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b0);
    cmp("quiet_idle", int'(state_o), 1);
    cyc(1'b1, 1'b1, 1'b0);
    cmp("wake_entry", int'(state_o), 2);
    cyc(1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b1);
    cmp("wake_3trans", int'(state_o), 2);
    cyc(1'b1, 1'b1, 1'b0);
    cmp("active_entry", int'(state_o), 3);
    cmp("active_eidle", int'(elec_idle), 0);
    cyc(1'b1, 1'b0, 1'b1);
    cmp("data_lat0", int'(rx_data), 0);
    cmp("valid_lat0", int'(rx_valid), 1);
    cyc(1'b1, 1'b1, 1'b0);
    cmp("data_lat1", int'(rx_data), 1);
    cyc(1'b1, 1'b0, 1'b1);

    // Idle entry: count quiet cycles after the last transition.
    n = 0;
    while (state_o == 2'd3 && n < 40) begin
      cyc(1'b1, 1'b0, 1'b1);
      n++;
    end
    cmp("idle_after_n", n, IDLE_TO);
    cmp("idle_state", int'(state_o), 1);
    cmp("idle_valid", int'(rx_valid), 0);
    cmp("idle_eidle", int'(elec_idle), 1);

    // Aborted wake.
    cyc(1'b1, 1'b1, 1'b0);
    cmp("wake2_entry", int'(state_o), 2);
    cyc(1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b1);
    cmp("abort_state", int'(state_o), 1);
    cmp("abort_eidle", int'(elec_idle), 1);
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b1);
    cmp("fresh_3trans", int'(state_o), 2);
    cyc(1'b1, 1'b1, 1'b0);
    cmp("fresh_active", int'(state_o), 3);

    // Transition on the 16th quiet cycle keeps the link ACTIVE.
    for (int i = 0; i < IDLE_TO - 1; i++) cyc(1'b1, 1'b1, 1'b0);
    cmp("bnd_15quiet", int'(state_o), 3);
    cyc(1'b1, 1'b0, 1'b1);
    cmp("bnd_stay", int'(state_o), 3);
    cmp("bnd_eidle", int'(elec_idle), 0);
    for (int i = 0; i < IDLE_TO - 1; i++) cyc(1'b1, 1'b0, 1'b1);
    cmp("bnd_restart", int'(state_o), 3);
    cyc(1'b1, 1'b0, 1'b1);
    cmp("bnd_idle", int'(state_o), 1);

    // Back to ACTIVE, then disable.
    cyc(1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b1);
    cmp("re_active", int'(state_o), 3);
    cyc(1'b0, 1'b1, 1'b0);
    cmp("dis_state", int'(state_o), 0);
    cmp("dis_rx_enb", int'(rx_enb), 0);
    cmp("dis_valid", int'(rx_valid), 0);
    cmp("dis_eidle", int'(elec_idle), 1);
    cyc(1'b1, 1'b1, 1'b0);
    cmp("reen_state", int'(state_o), 1);

    // Randomized traffic in segments of varying toggle density.
    cur  = 1'b0;
    mode = 30;
    for (int i = 0; i < 3000; i++) begin
      int r;
      if (i % 64 == 0) begin
        case ($urandom_range(0, 3))
          0: mode = 0;
          1: mode = 5;
          2: mode = 30;
          default: mode = 60;
        endcase
      end
      r = $urandom_range(0, 99);
      if (r < 8) begin
        cyc(r >= 2, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end else begin
        if ($urandom_range(0, 99) < mode) cur = ~cur;
        cyc(1'b1, cur, ~cur);
      end
      if ($urandom_range(0, 499) == 0) begin
        // Asynchronous reset between edges.
        #2 rst = 1'b0;
        #1;
        cmp("arst_state", int'(state_o), 0);
        cmp("arst_rx_enb", int'(rx_enb), 0);
        cmp("arst_eidle", int'(elec_idle), 1);
        @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk);
        #1;
      end
    end

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/diferencial_rx_ctrl.md
Name: diferencial_rx_ctrl

Overview:
- Controller that sequences the differential receiver front end: gates its enable, qualifies the sampled D+/D- pair, and tracks electrical-idle entry and exit.
- Sits between the receiver pads (dp/dn, already synchronized to clk) and the deserializer.
- Delivers registered serial bits and an electrical-idle flag to the link layer.

Parameters:
- IDLE_TIMEOUT, 16, consecutive quiet cycles in ACTIVE before electrical idle is declared (≥2).
- WAKE_TRANS, 4, dp transitions required in WAKE to declare the link active (≥1).
- CNT_W, 5, width of the internal counters; must hold max(IDLE_TIMEOUT, WAKE_TRANS).

Ports:
- clk  input  1  single clock, all state on rising edge.
- rst  input  1  reset, asynchronous, active-low (rst=0 resets).
- enb_req  input  1  link layer requests receiver on.
- dp  input  1  sampled D+.
- dn  input  1  sampled D-.
- rx_enb  output  1  enable to the differential receiver.
- rx_data  output  1  recovered serial bit.
- rx_valid  output  1  rx_data qualified.
- elec_idle  output  1  electrical idle flag.
- state_o  output  2  current state: OFF=0, IDLE=1, WAKE=2, ACTIVE=3.

Behaviour:
- All outputs registered. Reset values: rx_enb=0, rx_data=0, rx_valid=0, elec_idle=1, state_o=OFF. Counters and last_dp are cleared to 0.
- "diff" means dp!=dn (valid differential level). "trans" means diff and dp!=last_dp. last_dp updates every cycle in which diff is true.
- Priority in every state: enb_req=0 → OFF on the next edge, counters cleared. This overrides every other transition.
- OFF:
  - rx_enb=0, elec_idle=1, rx_valid=0.
  - enb_req=1 → IDLE.
- IDLE:
  - rx_enb=1, elec_idle=1, rx_valid=0.
  - diff → WAKE, with trans_cnt=0 and last_dp=dp.
- WAKE:
  - rx_enb=1, elec_idle=1, rx_valid=0.
  - !diff → IDLE, trans_cnt cleared.
  - trans → trans_cnt+1. When the incremented value equals WAKE_TRANS → ACTIVE, trans_cnt cleared, quiet_cnt=0.
  - diff without a transition: hold.
- ACTIVE:
  - elec_idle=0.
  - rx_data=dp and rx_valid=diff, both registered. This gives 1-cycle latency from dp/dn to rx_data/rx_valid.
  - trans clears quiet_cnt. Otherwise quiet_cnt increments; a !diff cycle counts as quiet.
  - quiet_cnt reaching IDLE_TIMEOUT → IDLE. On that same edge: elec_idle=1, rx_valid=0, quiet_cnt cleared.
- Counters saturate and never wrap.
- A transition on the cycle quiet_cnt would hit IDLE_TIMEOUT wins: quiet_cnt clears and the state stays ACTIVE.
- Asynchronous reset mid-frame forces all reset values immediately, regardless of the clock.
- On reset deassertion, the first edge evaluates the OFF rules.

Decomposition:
- Shared package (diferencial_pkg):
  - state encoding constants ST_OFF/ST_IDLE/ST_WAKE/ST_ACTIVE.
  - default IDLE_TIMEOUT/WAKE_TRANS.
- One natural sub-module: diferencial_edge_cnt. It is a saturating counter with clear/increment and a compare-to-limit output, instantiated twice (trans_cnt, quiet_cnt).
- The FSM and output registers stay in the top module.

Test Plan:
- Reset: rst=0 with enb_req=1 and dp/dn toggling → rx_enb=0, elec_idle=1, state_o=0. Release rst → state_o=1 one edge later.
- Wake-up: enb_req=1, dp/dn=0/0 for 5 cycles, then dp alternating 1,0,1,0,1 with dn=~dp → state_o goes 1→2 on the first diff cycle. After the 4th transition: state_o=3, elec_idle=0. rx_data follows dp with 1-cycle latency, rx_valid=1.
- Aborted wake: in WAKE after 2 transitions, drive dp=dn=1 → state_o=1, elec_idle stays 1. A new diff needs 4 fresh transitions to reach ACTIVE.
- Idle entry: in ACTIVE hold dp=1, dn=0 constant → elec_idle=1 and state_o=1 exactly 16 cycles after the last transition. rx_valid=0 on the same edge.
- Boundary: in ACTIVE toggle dp exactly on quiet cycle 16 → remain ACTIVE, quiet_cnt restarts, elec_idle stays 0.
- Disable: enb_req=0 during ACTIVE → next edge state_o=0, rx_enb=0, rx_valid=0, elec_idle=1. Reassert → IDLE after 1 edge.
